// File: rtl/fetch_unit.sv
// fetch_unit: program-counter / fetch stage.
//
// Holds the PC that addresses the instruction ROM. A three-state sequencer
// (IDLE -> RUN -> DONE) launches a program from StartAddr and stops on Halt.
// In RUN the PC holds on Halt or Stall, takes Target on jump_en, and
// otherwise increments (wrapping modulo 2^PC_W).
//
// Ports:
//   Clk        in   clock, rising-edge
//   Reset      in   synchronous active-high reset (beats Start)
//   Start      in   level; loads StartAddr and holds the block in IDLE
//   StartAddr  in   program entry address
//   Halt       in   halt indication for the current instruction
//   Stall      in   freeze PC this cycle
//   jump_en    in   taken redirect from the decoder
//   Target     in   absolute redirect address
//   ProgCtr    out  registered PC
//   Running    out  state == RUN
//   Done       out  state == DONE
//   InstCount  out  (FETCH_PERF_CNT_EN only) non-stalled RUN cycles, saturating
//   TakenCount out  (FETCH_PERF_CNT_EN only) applied redirects, saturating
//
// Optional feature macro: FETCH_PERF_CNT_EN adds the performance counters.
module fetch_unit #(
  parameter int unsigned PC_W = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [PC_W-1:0] StartAddr,
  input  logic            Halt,
  input  logic            Stall,
  input  logic            jump_en,
  input  logic [PC_W-1:0] Target,
  output logic [PC_W-1:0] ProgCtr,
  output logic            Running,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]     InstCount,
  output logic [15:0]     TakenCount,
`endif
  output logic            Done
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_d;
  logic            w_inst_fire;
  logic            w_redirect;

  always_comb begin
    w_state_d   = r_state;
    w_pc_d      = r_pc;
    w_inst_fire = 1'b0;
    w_redirect  = 1'b0;
    if (Start) begin
      w_state_d = StIdle;
      w_pc_d    = StartAddr;
    end else begin
      unique case (r_state)
        StIdle: w_state_d = StRun;
        StRun: begin
          // The halting instruction itself is counted as executed.
          w_inst_fire = !Stall;
          if (Halt) begin
            w_state_d = StDone;
          end else if (Stall) begin
            w_pc_d = r_pc;
          end else if (jump_en) begin
            w_pc_d     = Target;
            w_redirect = 1'b1;
          end else begin
            w_pc_d = r_pc + 1'b1;
          end
        end
        StDone: w_state_d = StDone;
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= StIdle;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
    end
  end

  assign ProgCtr = r_pc;
  assign Running = (r_state == StRun);
  assign Done    = (r_state == StDone);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_inst_cnt;
  logic [15:0] r_taken_cnt;

  always_ff @(posedge Clk) begin
    if (Reset || Start) begin
      r_inst_cnt  <= '0;
      r_taken_cnt <= '0;
    end else begin
      if (w_inst_fire && (r_inst_cnt != 16'hFFFF)) begin
        r_inst_cnt <= r_inst_cnt + 16'd1;
      end
      if (w_redirect && (r_taken_cnt != 16'hFFFF)) begin
        r_taken_cnt <= r_taken_cnt + 16'd1;
      end
    end
  end

  assign InstCount  = r_inst_cnt;
  assign TakenCount = r_taken_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// stimulus compared against a behavioural model of the fetch stage.
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [15:0] StartAddr = 16'h0000;
  logic        Halt = 1'b0;
  logic        Stall = 1'b0;
  logic        jump_en = 1'b0;
  logic [15:0] Target = 16'h0000;
  logic [15:0] ProgCtr;
  logic        Running;
  logic        Done;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] InstCount;
  logic [15:0] TakenCount;
`endif

  fetch_unit #(.PC_W(16)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .StartAddr (StartAddr),
    .Halt      (Halt),
    .Stall     (Stall),
    .jump_en   (jump_en),
    .Target    (Target),
    .ProgCtr   (ProgCtr),
    .Running   (Running),
`ifdef FETCH_PERF_CNT_EN
    .InstCount (InstCount),
    .TakenCount(TakenCount),
`endif
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: phase of the program and the PC as plain integers.
  localparam int PhIdle = 0;
  localparam int PhRun  = 1;
  localparam int PhDone = 2;
  int m_pc    = 0;
  int m_ph    = PhIdle;
  int m_inst  = 0;
  int m_taken = 0;

  // Advance the model with the current inputs, then clock the DUT.
  task automatic step();
    if (Reset) begin
      m_pc = 0; m_ph = PhIdle; m_inst = 0; m_taken = 0;
    end else if (Start) begin
      m_pc = int'(StartAddr); m_ph = PhIdle; m_inst = 0; m_taken = 0;
    end else if (m_ph == PhIdle) begin
      m_ph = PhRun;
    end else if (m_ph == PhRun) begin
      if (!Stall && m_inst < 65535) m_inst++;
      if (Halt) m_ph = PhDone;
      else if (Stall) m_pc = m_pc;
      else if (jump_en) begin
        m_pc = int'(Target);
        if (m_taken < 65535) m_taken++;
      end else m_pc = (m_pc + 1) % 65536;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic quiet();
    Reset = 0; Start = 0; Halt = 0; Stall = 0; jump_en = 0;
  endtask

  task automatic test_reset();
    Reset = 1; Start = 1; StartAddr = 16'h1234; jump_en = 1; Target = 16'h0BAD;
    step(); step();
    total++;
    if (ProgCtr !== 16'h0000) begin
      bad++; $display("FAIL reset_pc: got %h want 0000", ProgCtr);
    end
    total++;
    if (Running !== 1'b0 || Done !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got run=%b done=%b want 0 0", Running, Done);
    end
    quiet();
  endtask

  task automatic test_launch();
    logic [15:0] exp_seq [5];
    exp_seq = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
    Start = 1; StartAddr = 16'h0000;
    step();
    total++;
    if (ProgCtr !== 16'h0000 || Running !== 1'b0) begin
      bad++; $display("FAIL launch_idle: got pc=%h run=%b want 0000 0", ProgCtr, Running);
    end
    Start = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (ProgCtr !== exp_seq[i]) begin
        bad++; $display("FAIL launch_seq[%0d]: got %h want %h", i, ProgCtr, exp_seq[i]);
      end
    end
    total++;
    if (Running !== 1'b1) begin
      bad++; $display("FAIL launch_running: got %b want 1", Running);
    end
  endtask

  task automatic test_jump();
    for (int i = 0; i < 40 && m_pc != 16; i++) step();
    total++;
    if (ProgCtr !== 16'h0010) begin
      bad++; $display("FAIL jump_pre: got %h want 0010", ProgCtr);
    end
    jump_en = 1; Target = 16'h0003;
    step();
    total++;
    if (ProgCtr !== 16'h0003) begin
      bad++; $display("FAIL jump_taken: got %h want 0003", ProgCtr);
    end
    jump_en = 0;
    step();
    total++;
    if (ProgCtr !== 16'h0004) begin
      bad++; $display("FAIL jump_after: got %h want 0004", ProgCtr);
    end
  endtask

  task automatic test_halt();
    Start = 1; StartAddr = 16'h04A1; step();
    Start = 0; step();
    Halt = 1; step();
    total++;
    if (Done !== 1'b1 || Running !== 1'b0 || ProgCtr !== 16'h04A1) begin
      bad++; $display("FAIL halt: got done=%b run=%b pc=%h want 1 0 04a1", Done, Running, ProgCtr);
    end
    Halt = 0; jump_en = 1; Target = 16'h0055;
    step(); step();
    total++;
    if (Done !== 1'b1 || ProgCtr !== 16'h04A1) begin
      bad++; $display("FAIL halt_hold: got done=%b pc=%h want 1 04a1", Done, ProgCtr);
    end
    jump_en = 0; Start = 1; StartAddr = 16'h0201;
    step();
    total++;
    if (Done !== 1'b0 || ProgCtr !== 16'h0201) begin
      bad++; $display("FAIL halt_restart: got done=%b pc=%h want 0 0201", Done, ProgCtr);
    end
    Start = 0;
  endtask

  task automatic test_wrap_stall();
    Start = 1; StartAddr = 16'hFFFF; step();
    Start = 0; step();
    total++;
    if (ProgCtr !== 16'hFFFF || Running !== 1'b1) begin
      bad++; $display("FAIL wrap_pre: got pc=%h run=%b want ffff 1", ProgCtr, Running);
    end
    step();
    total++;
    if (ProgCtr !== 16'h0000) begin
      bad++; $display("FAIL wrap: got %h want 0000", ProgCtr);
    end
    Stall = 1; jump_en = 1; Target = 16'h0777;
    step();
    total++;
    if (ProgCtr !== 16'h0000) begin
      bad++; $display("FAIL stall_vs_jump: got %h want 0000", ProgCtr);
    end
    Stall = 0; jump_en = 0;
  endtask

  task automatic test_reset_mid_run();
    Start = 1; StartAddr = 16'h0452; step();
    Start = 0; step();
    jump_en = 1; Target = 16'h0099; Reset = 1;
    step();
    total++;
    if (ProgCtr !== 16'h0000 || Running !== 1'b0 || Done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_run: got pc=%h run=%b done=%b want 0000 0 0",
               ProgCtr, Running, Done);
    end
    Reset = 0; jump_en = 0;
    step();
    total++;
    if (ProgCtr !== 16'h0000 || Running !== 1'b1) begin
      bad++; $display("FAIL reset_relaunch: got pc=%h run=%b want 0000 1", ProgCtr, Running);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Reset     = ($urandom_range(0, 39) == 0);
      Start     = ($urandom_range(0, 19) == 0);
      StartAddr = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      Halt      = ($urandom_range(0, 14) == 0);
      Stall     = ($urandom_range(0, 3) == 0);
      jump_en   = ($urandom_range(0, 3) == 0);
      Target    = ($urandom_range(0, 4) == 0) ? ProgCtr : 16'($urandom);
      step();
      total++;
      if (ProgCtr !== 16'(m_pc) || Running !== (m_ph == PhRun) || Done !== (m_ph == PhDone)) begin
        bad++;
        $display("FAIL random[%0d]: got pc=%h run=%b done=%b want %h %b %b", i, ProgCtr,
                 Running, Done, 16'(m_pc), m_ph == PhRun, m_ph == PhDone);
      end
`ifdef FETCH_PERF_CNT_EN
      total++;
      if (InstCount !== 16'(m_inst) || TakenCount !== 16'(m_taken)) begin
        bad++;
        $display("FAIL random_cnt[%0d]: got inst=%0d taken=%0d want %0d %0d", i, InstCount,
                 TakenCount, m_inst, m_taken);
      end
`endif
    end
    quiet();
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    Reset = 1; step();
    Reset = 0; Start = 1; StartAddr = 16'h0000; step();
    Start = 0; step();
    for (int i = 0; i < 10; i++) begin
      Stall   = (i == 2 || i == 5);
      jump_en = (i == 0 || i == 4 || i == 7);
      Target  = 16'(i * 3);
      step();
    end
    Stall = 0; jump_en = 0;
    total++;
    if (InstCount !== 16'd8 || TakenCount !== 16'd3) begin
      bad++; $display("FAIL perf_counts: got inst=%0d taken=%0d want 8 3", InstCount, TakenCount);
    end
    Start = 1; step();
    total++;
    if (InstCount !== 16'd0 || TakenCount !== 16'd0) begin
      bad++; $display("FAIL perf_clear: got inst=%0d taken=%0d want 0 0", InstCount, TakenCount);
    end
    Start = 0;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_launch();
    test_jump();
    test_halt();
    test_wrap_stall();
    test_reset_mid_run();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
